wide_cmp_seq: RTL and testbench
===============================

// Module: wide_cmp_seq
// PURPOSE
//  Word-serial magnitude comparator controller for operands wider than 4 bits.
//  Captures two NIBBLES*4-bit operands on a start handshake.
//  Steps one 4-bit nibble_cmp slice from MSB nibble to LSB nibble, one nibble per cycle.
//  Reports a registered one-hot GT/EQ/LT result with a done pulse.
//  Sits between a requesting master and the shared 4-bit compare slice.
// PARAMETERS
//  NIBBLES   4   operand width in nibbles (W = 4*NIBBLES); legal range 2..16
// PORTS
//  clk       in   1    single clock, all logic on posedge
//  rst       in   1    synchronous, active-high reset
//  start     in   1    request; accepted only when in_ready=1
//  in_ready  out  1    block idle and able to accept start
//  A         in   W    operand A, sampled on accepted start
//  B         in   W    operand B, sampled on accepted start
//  busy      out  1    compare in progress (state CMP or DONE)
//  done      out  1    one-cycle pulse, result valid
//  Y2        out  1    A>B, registered, held until next accepted start
//  Y1        out  1    A==B, registered, held
//  Y0        out  1    A<B, registered, held
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, busy=0, done=0, Y2/Y1/Y0=000.
//    Operand regs and nibble index are cleared.
//    A reset mid-operation aborts the compare: no done pulse, outputs 000 next cycle.
//  - FSM IDLE->CMP on start&in_ready.
//    On that edge: A,B captured, idx=NIBBLES-1, Y2/Y1/Y0 cleared to 000.
//  - CMP: nibble_cmp is fed A_q[idx*4+:4] and B_q[idx*4+:4].
//    * Slice GT or LT: record the result, go to DONE.
//    * Slice EQ and idx!=0: idx decrements, remain in CMP.
//    * Slice EQ and idx==0: record EQ, go to DONE.
//  - DONE: done=1 for exactly one cycle; Y outputs already valid this cycle; then IDLE.
//  - in_ready = (state==IDLE).
//    start while not idle is ignored; no queueing; operand changes do not affect the compare.
//  - After the first completion exactly one of Y2/Y1/Y0 is high. They are 000 only after reset/start.
//  - Latency, start accepted at edge 0, first differing nibble at MSB-relative position d (1..NIBBLES):
//    * done is high in cycle d+1.
//    * If equal, done is high in cycle NIBBLES+1.
//  - Back-to-back throughput: a new start is accepted in the cycle after done.
// CONFIGURATION
//  WIDE_CMP_EARLY_EXIT_EN defined: CMP exits at the first unequal nibble (latency above).
//  WIDE_CMP_EARLY_EXIT_EN undefined: CMP always runs all NIBBLES cycles.
//    * done is always in cycle NIBBLES+1.
//    * The first unequal nibble's verdict is latched and sticky; lower nibbles cannot override it.
//    * Result values are identical in both builds.
// STRUCTURE
//  Package wide_cmp_pkg:
//    * typedef enum logic[1:0] state_t {S_IDLE,S_CMP,S_DONE}
//    * localparams RES_GT=3'b100, RES_EQ=3'b010, RES_LT=3'b001
//  Sub-module nibble_cmp: combinational 4-bit magnitude compare (a,b -> gt,eq,lt), one instance.
//  Top holds FSM, operand regs, idx counter, result regs.
// TESTING (NIBBLES=4; cycle counts give both builds as early/full)
//  1. Reset: rst=1 for 2 cycles -> Y=000, done=0, busy=0, in_ready=1.
//  2. A=16'h8000, B=16'h7FFF, start -> Y2=1, done in cycle 2 / 5.
//  3. A=B=16'h1234, start -> Y1=1, done in cycle 5 (both builds).
//  4. A=16'h1230, B=16'h1231 -> Y0=1, done in cycle 5.
//     A=16'h0F00, B=16'h0E99 -> Y2=1, done in cycle 3 / 5.
//  5. Start A=16'h0001, B=16'h0002; in cycle 2 pulse start with A=16'hFFFF, B=0 -> ignored.
//     Y0=1, single done; next start is accepted after done.
//  6. rst=1 in cycle 2 of a compare -> cycle 3: IDLE, Y=000, no done.
//     A following start completes normally.

Source files
------------

// File: rtl/wide_cmp_pkg.sv
// Shared types and result encodings for the word-serial wide comparator.
// Latency: none (declarations only).
// Backpressure: not applicable.
package wide_cmp_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMP  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // One-hot verdicts, bit order {GT, EQ, LT}
   localparam logic [2:0] RES_GT   = 3'b100;
   localparam logic [2:0] RES_EQ   = 3'b010;
   localparam logic [2:0] RES_LT   = 3'b001;
   localparam logic [2:0] RES_NONE = 3'b000;

endpackage

// File: rtl/nibble_cmp.sv
// Combinational 4-bit magnitude compare slice, one-hot gt/eq/lt.
// Latency: zero cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
module nibble_cmp (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       gt,
   output logic       eq,
   output logic       lt
);

   // Unsigned magnitude compare of one nibble pair
   always_comb begin
      gt = (a > b);
      eq = (a == b);
      lt = (a < b);
   end

endmodule

// File: rtl/wide_cmp_seq.sv
// Word-serial wide magnitude comparator, walking MSB nibble to LSB nibble (macro WIDE_CMP_EARLY_EXIT_EN).
// Latency: done d+1 cycles after start (d = first unequal nibble from MSB), or NIBBLES+1 when equal / no early exit.
// Backpressure: start accepted only when in_ready (IDLE); starts while busy are dropped, never queued.
module wide_cmp_seq
   import wide_cmp_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] A,
   input  logic [4*NIBBLES-1:0] B,
   output logic                 busy,
   output logic                 done,
   output logic                 Y2,
   output logic                 Y1,
   output logic                 Y0
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);

   state_t          state;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [IW-1:0]   idx;
   logic [2:0]      y_q;
   logic [3:0]      a_nib;
   logic [3:0]      b_nib;
   logic            s_gt;
   logic            s_eq;
   logic            s_lt;
   logic [2:0]      slice_res;
   logic            last_nib;
`ifndef WIDE_CMP_EARLY_EXIT_EN
   // Sticky verdict of the most significant unequal nibble seen so far
   logic [2:0]      verdict_q;
   logic [2:0]      verdict_nxt;
`endif

   // Select the nibble pair currently under compare
   always_comb begin
      a_nib     = a_q[{idx, 2'b00} +: 4];
      b_nib     = b_q[{idx, 2'b00} +: 4];
      slice_res = {s_gt, s_eq, s_lt};
      last_nib  = (idx == '0);
   end

   nibble_cmp u_nibble_cmp (
      .a  (a_nib),
      .b  (b_nib),
      .gt (s_gt),
      .eq (s_eq),
      .lt (s_lt)
   );

`ifndef WIDE_CMP_EARLY_EXIT_EN
   // First unequal nibble wins; lower nibbles only matter while still equal
   always_comb begin
      verdict_nxt = verdict_q;
      if (verdict_q == RES_EQ && !s_eq) begin
         verdict_nxt = slice_res;
      end
   end
`endif

   // Control FSM with operand capture, nibble index and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         y_q       <= RES_NONE;
         a_q       <= '0;
         b_q       <= '0;
         idx       <= '0;
`ifndef WIDE_CMP_EARLY_EXIT_EN
         verdict_q <= RES_NONE;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start && in_ready) begin
                  a_q      <= A;
                  b_q      <= B;
                  idx      <= IW'(NIBBLES - 1);
                  y_q      <= RES_NONE;
                  state    <= S_CMP;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
`ifndef WIDE_CMP_EARLY_EXIT_EN
                  verdict_q <= RES_EQ;
`endif
               end
            end
            S_CMP: begin
`ifdef WIDE_CMP_EARLY_EXIT_EN
               if (!s_eq) begin
                  y_q   <= slice_res;
                  state <= S_DONE;
                  done  <= 1'b1;
               end else if (last_nib) begin
                  y_q   <= RES_EQ;
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  idx <= idx - 1'b1;
               end
`else
               verdict_q <= verdict_nxt;
               if (last_nib) begin
                  y_q   <= verdict_nxt;
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  idx <= idx - 1'b1;
               end
`endif
            end
            S_DONE: begin
               done     <= 1'b0;
               busy     <= 1'b0;
               in_ready <= 1'b1;
               state    <= S_IDLE;
            end
            default: begin
               done     <= 1'b0;
               busy     <= 1'b0;
               in_ready <= 1'b1;
               state    <= S_IDLE;
            end
         endcase
      end
   end

   assign Y2 = y_q[2];
   assign Y1 = y_q[1];
   assign Y0 = y_q[0];

endmodule

// File: tb/tb_wide_cmp_seq.sv
// Directed bench for wide_cmp_seq with a cycle-level reference model.
// Latency: expected done cycles are hand-computed per build (early exit vs full walk).
// Backpressure: exercises ignored starts while busy and restart right after done.
module tb_wide_cmp_seq;

   localparam int NIB = 4;

`ifdef WIDE_CMP_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic        busy;
   logic        done;
   logic        Y2;
   logic        Y1;
   logic        Y0;

   int checks = 0;
   int passed = 0;

   wide_cmp_seq #(.NIBBLES(NIB)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_ready (in_ready),
      .A        (A),
      .B        (B),
      .busy     (busy),
      .done     (done),
      .Y2       (Y2),
      .Y1       (Y1),
      .Y0       (Y0)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
   endtask

   // Reference model: cycles remaining until the done cycle, plus the verdict
   int          m_left = 0;
   bit          m_done = 1'b0;
   logic [2:0]  m_y    = 3'b000;
   logic [2:0]  m_res  = 3'b000;
   bit          chk_en = 1'b0;

   function automatic int cmp_cycles(input logic [15:0] a, input logic [15:0] b);
      if (!EARLY) return NIB;
      for (int i = NIB - 1; i >= 0; i--) begin
         if (a[i*4 +: 4] != b[i*4 +: 4]) return NIB - i;
      end
      return NIB;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_left = 0;
         m_done = 1'b0;
         m_y    = 3'b000;
         chk_en = 1'b1;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_done = 1'b1;
            m_y    = m_res;
         end
      end else if (start) begin
         m_y    = 3'b000;
         m_res  = (A > B) ? 3'b100 : ((A == B) ? 3'b010 : 3'b001);
         m_left = cmp_cycles(A, B);
      end
   end

   // Every-cycle compare of all outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         logic [5:0] exp_v;
         exp_v = {(m_left == 0 && !m_done), (m_left > 0 || m_done), m_done, m_y};
         check("cycle_outputs", {26'd0, in_ready, busy, done, Y2, Y1, Y0}, {26'd0, exp_v});
      end
   end

   task automatic wait_done(inout int cyc);
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] ey, input int ecyc, input string nm);
      int cyc;
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      wait_done(cyc);
      check({nm, "_done_cycle"}, cyc, ecyc);
      check({nm, "_result"}, {29'd0, Y2, Y1, Y0}, {29'd0, ey});
   endtask

   initial begin
      int cyc;
      int ndone;
      rst = 1'b1; start = 1'b0; A = '0; B = '0;
      repeat (2) @(negedge clk);
      check("reset_y", {29'd0, Y2, Y1, Y0}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;

      run_op(16'h8000, 16'h7FFF, 3'b100, EARLY ? 2 : 5, "gt_msb");
      run_op(16'h1234, 16'h1234, 3'b010, 5, "eq");
      run_op(16'h1230, 16'h1231, 3'b001, 5, "lt_lsb");
      run_op(16'h0F00, 16'h0E99, 3'b100, EARLY ? 3 : 5, "gt_nib2");
      run_op(16'hFFFF, 16'hFFFE, 3'b100, 5, "gt_lsb");
      run_op(16'h0000, 16'h1000, 3'b001, EARLY ? 2 : 5, "lt_msb");
      run_op(16'hABCD, 16'hAB0D, 3'b100, EARLY ? 4 : 5, "gt_nib3");

      // Start while busy is ignored, operand changes do not disturb the compare
      @(negedge clk);
      A = 16'h0001; B = 16'h0002; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      A = 16'hFFFF; B = 16'h0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 3;
      wait_done(cyc);
      check("ignored_done_cycle", cyc, 5);
      check("ignored_result", {29'd0, Y2, Y1, Y0}, 32'b001);
      // Restart in the cycle right after done
      @(negedge clk);
      check("after_done_ready", {31'd0, in_ready}, 32'd1);
      A = 16'h0055; B = 16'h0055; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart_busy", {31'd0, busy}, 32'd1);
      cyc = 1;
      wait_done(cyc);
      check("restart_done_cycle", cyc, 5);
      check("restart_result", {29'd0, Y2, Y1, Y0}, 32'b010);

      // Reset in the middle of a compare aborts it
      @(negedge clk);
      A = 16'h1234; B = 16'h1234; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_y", {29'd0, Y2, Y1, Y0}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;
      ndone = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort_no_done", ndone, 0);
      run_op(16'hA5A5, 16'hA5A4, 3'b100, 5, "after_abort");

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
